// File: rtl/mul_err_pkg.sv
// Shared types and width defaults for the approximate-multiplier error collector.
package mul_err_pkg;

  localparam int W_DEF     = 16;
  localparam int CNT_W_DEF = 20;
  localparam int PROD_W    = 2 * W_DEF;
  localparam int SUM_W_DEF = PROD_W + CNT_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_ed_calc.sv
// Two-stage pipeline: capture the beat, form the exact product, then the
// absolute error distance against the approximate product.
module mul_ed_calc #(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  input  logic signed [2*W-1:0] prod,
  output logic                  ed_valid,
  output logic [2*W-1:0]        ed
);

  localparam int PW = 2 * W;

  logic                 v1;
  logic                 v2;
  logic signed [W-1:0]  a1;
  logic signed [W-1:0]  b1;
  logic signed [PW-1:0] p1;
  logic signed [PW-1:0] p2;
  logic signed [PW-1:0] exact2;
  logic signed [PW:0]   diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      a1     <= '0;
      b1     <= '0;
      p1     <= '0;
      p2     <= '0;
      exact2 <= '0;
    end else begin
      v1 <= valid;
      v2 <= v1;
      if (valid) begin
        a1 <= a;
        b1 <= b;
        p1 <= prod;
      end
      // Full-width signed product: (-2^(W-1))^2 = +2^(2W-2) still fits.
      if (v1) begin
        exact2 <= PW'(a1) * PW'(b1);
        p2     <= p1;
      end
    end
  end

  // One extra bit so the difference cannot overflow; |diff| always fits PW bits.
  assign diff     = {exact2[PW-1], exact2} - {p2[PW-1], p2};
  assign ed       = diff[PW] ? PW'(-diff) : PW'(diff);
  assign ed_valid = v2;

endmodule

// File: rtl/mul_err_collector.sv
// Streaming error-statistics sink for approximate multipliers: sweep FSM,
// input handshake and saturating accumulators.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | accepting beats until the in_last beat
// DRAIN | two cycles letting the ED pipeline empty
// DONE  | statistics final, held until start or reset
module mul_err_collector
  import mul_err_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = 2 * W + CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   in_a,
  input  logic signed [W-1:0]   in_b,
  input  logic signed [2*W-1:0] in_prod,
  input  logic                  in_last,
  output logic                  busy,
  output logic                  stat_valid,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [SUM_W-1:0]      sum_ed,
  output logic [2*W-1:0]        max_ed,
  output logic                  sat
);

  localparam int PW = 2 * W;

  state_t        state;
  logic          drain_cnt;
  logic          accept;
  logic          clear;
  logic          ed_valid;
  logic [PW-1:0] ed;
  logic [SUM_W:0] sum_next;

  assign accept   = in_ready & in_valid;
  assign clear    = start & ((state == IDLE) | (state == DONE));
  assign sum_next = {1'b0, sum_ed} + (SUM_W + 1)'(ed);

  mul_ed_calc #(.W(W)) u_ed (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (accept),
    .a        (in_a),
    .b        (in_b),
    .prod     (in_prod),
    .ed_valid (ed_valid),
    .ed       (ed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_cnt  <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      stat_valid <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
      sat        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            stat_valid <= 1'b0;
          end else if (state == DONE) begin
            stat_valid <= 1'b1;
          end
        end
        RUN: begin
          if (in_valid && in_last) begin
            state     <= DRAIN;
            in_ready  <= 1'b0;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // The ED pipeline is always empty in IDLE/DONE, so clear never races an update.
      if (clear) begin
        sample_cnt <= '0;
        err_cnt    <= '0;
        sum_ed     <= '0;
        max_ed     <= '0;
        sat        <= 1'b0;
      end else if (ed_valid) begin
        if (&sample_cnt) sat <= 1'b1;
        else             sample_cnt <= sample_cnt + 1'b1;
        if (ed != '0) begin
          if (&err_cnt) sat <= 1'b1;
          else          err_cnt <= err_cnt + 1'b1;
        end
        if (sum_next[SUM_W]) begin
          sum_ed <= '1;
          sat    <= 1'b1;
        end else begin
          sum_ed <= sum_next[SUM_W-1:0];
        end
        if (ed > max_ed) max_ed <= ed;
      end
    end
  end

endmodule

// File: tb/tb_mul_err_collector.sv
// Directed bench for mul_err_collector: default instance plus a CNT_W=2 copy
// driven by the same stimulus to exercise counter saturation.
module tb_mul_err_collector;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic signed [15:0] in_a = '0;
  logic signed [15:0] in_b = '0;
  logic signed [31:0] in_prod = '0;

  logic        in_ready, busy, stat_valid, sat;
  logic [19:0] sample_cnt, err_cnt;
  logic [51:0] sum_ed;
  logic [31:0] max_ed;

  logic        s_ready, s_busy, s_stat_valid, s_sat;
  logic [1:0]  s_sample_cnt, s_err_cnt;
  logic [33:0] s_sum_ed;
  logic [31:0] s_max_ed;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_err_collector dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_prod(in_prod),
    .in_last(in_last), .busy(busy), .stat_valid(stat_valid),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed),
    .max_ed(max_ed), .sat(sat)
  );

  mul_err_collector #(.W(16), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(s_ready), .in_a(in_a), .in_b(in_b), .in_prod(in_prod),
    .in_last(in_last), .busy(s_busy), .stat_valid(s_stat_valid),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .sum_ed(s_sum_ed),
    .max_ed(s_max_ed), .sat(s_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int a, input int b, input int p, input bit last);
    in_valid = 1'b1;
    in_a     = 16'(a);
    in_b     = 16'(b);
    in_prod  = 32'(p);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!stat_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (stat_valid !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout stat_valid=%0b expected 1", stat_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({in_ready, busy, stat_valid, sat} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {in_ready, busy, stat_valid, sat});
    end
    checks++;
    if (sample_cnt !== 0 || err_cnt !== 0 || sum_ed !== 0 || max_ed !== 0) begin
      failures++;
      $display("FAIL reset_stats got=%0d/%0d/%0d/%0d exp=0/0/0/0", sample_cnt, err_cnt, sum_ed, max_ed);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({in_ready, busy} !== 2'b00) begin
      failures++;
      $display("FAIL idle_hold got=%b exp=00", {in_ready, busy});
    end
  endtask

  task automatic test_single();
    pulse_start();
    checks++;
    if ({in_ready, busy} !== 2'b11) begin
      failures++;
      $display("FAIL run_entry got=%b exp=11", {in_ready, busy});
    end
    beat(3, -5, -15, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL drain_ready got=%0b exp=0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (stat_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_valid got=%0b exp=0 at k+2", stat_valid);
    end
    tick();
    checks++;
    if (stat_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_latency got valid=%0b busy=%0b exp 1/0 at k+3", stat_valid, busy);
    end
    checks++;
    if (sample_cnt !== 1 || err_cnt !== 0 || sum_ed !== 0 || max_ed !== 0) begin
      failures++;
      $display("FAIL single_stats got=%0d/%0d/%0d/%0d exp=1/0/0/0", sample_cnt, err_cnt, sum_ed, max_ed);
    end
  endtask

  task automatic test_multi();
    pulse_start();
    beat(100, 100, 9984, 1'b0);
    beat(-7, 9, -60, 1'b0);
    beat(-32768, -32768, 0, 1'b1);
    wait_done();
    checks++;
    if (sample_cnt !== 3 || err_cnt !== 3 || sat !== 1'b0) begin
      failures++;
      $display("FAIL multi_counts got=%0d/%0d sat=%0b exp=3/3 sat=0", sample_cnt, err_cnt, sat);
    end
    checks++;
    if (sum_ed !== 52'd1073741843 || max_ed !== 32'd1073741824) begin
      failures++;
      $display("FAIL multi_sum_max got=%0d/%0d exp=1073741843/1073741824", sum_ed, max_ed);
    end
  endtask

  task automatic test_gaps();
    pulse_start();
    beat(2, 3, 6, 1'b0);
    in_a = 16'sd50; in_b = 16'sd50; in_prod = 32'sd7; in_last = 1'b1;
    tick();
    beat(-4, 5, -21, 1'b0);
    in_a = 16'sd99; in_prod = 32'sd1;
    repeat (2) tick();
    beat(10, -10, -90, 1'b1);
    in_valid = 1'b1; in_a = 16'sd1000; in_b = 16'sd1000; in_prod = 32'sd0; in_last = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL gaps_drain_ready got=%0b exp=0", in_ready);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    wait_done();
    checks++;
    if (sample_cnt !== 3 || err_cnt !== 2 || sum_ed !== 11 || max_ed !== 10) begin
      failures++;
      $display("FAIL gaps_stats got=%0d/%0d/%0d/%0d exp=3/2/11/10", sample_cnt, err_cnt, sum_ed, max_ed);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 5; i++) beat(1, 1, 0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, stat_valid, sat} !== 4'b0000 || sample_cnt !== 0 || sum_ed !== 0) begin
      failures++;
      $display("FAIL midrun_reset got flags=%b sample=%0d sum=%0d exp 0000/0/0",
               {in_ready, busy, stat_valid, sat}, sample_cnt, sum_ed);
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({in_ready, busy, stat_valid} !== 3'b000) begin
      failures++;
      $display("FAIL midrun_idle got=%b exp=000", {in_ready, busy, stat_valid});
    end
    pulse_start();
    beat(2, 2, 4, 1'b1);
    wait_done();
    checks++;
    if (sample_cnt !== 1 || err_cnt !== 0 || sum_ed !== 0 || max_ed !== 0) begin
      failures++;
      $display("FAIL midrun_new_sweep got=%0d/%0d/%0d/%0d exp=1/0/0/0", sample_cnt, err_cnt, sum_ed, max_ed);
    end
  endtask

  task automatic test_start_control();
    pulse_start();
    beat(3, 3, 8, 1'b0);
    repeat (3) tick();
    pulse_start();
    tick();
    checks++;
    if (sample_cnt !== 1 || busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL start_in_run got sample=%0d busy=%0b ready=%0b exp 1/1/1", sample_cnt, busy, in_ready);
    end
    beat(0, 0, 5, 1'b1);
    wait_done();
    checks++;
    if (sample_cnt !== 2 || err_cnt !== 2 || sum_ed !== 6 || max_ed !== 5) begin
      failures++;
      $display("FAIL start_run_stats got=%0d/%0d/%0d/%0d exp=2/2/6/5", sample_cnt, err_cnt, sum_ed, max_ed);
    end
    pulse_start();
    checks++;
    if (stat_valid !== 1'b0 || sample_cnt !== 0 || err_cnt !== 0 || sum_ed !== 0 || max_ed !== 0) begin
      failures++;
      $display("FAIL start_in_done got valid=%0b stats=%0d/%0d/%0d/%0d exp 0 and 0/0/0/0",
               stat_valid, sample_cnt, err_cnt, sum_ed, max_ed);
    end
    checks++;
    if ({in_ready, busy} !== 2'b11) begin
      failures++;
      $display("FAIL start_in_done_run got=%b exp=11", {in_ready, busy});
    end
    beat(4, 4, 16, 1'b1);
    wait_done();
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int i = 0; i < 4; i++) beat(1, 1, 0, 1'b0);
    beat(1, 1, 0, 1'b1);
    wait_done();
    checks++;
    if (s_sample_cnt !== 2'd3 || s_err_cnt !== 2'd3 || s_sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_counts got=%0d/%0d sat=%0b exp=3/3 sat=1", s_sample_cnt, s_err_cnt, s_sat);
    end
    checks++;
    if (s_sum_ed !== 34'd5 || s_max_ed !== 32'd1 || s_stat_valid !== 1'b1) begin
      failures++;
      $display("FAIL sat_sum got sum=%0d max=%0d valid=%0b exp 5/1/1", s_sum_ed, s_max_ed, s_stat_valid);
    end
    checks++;
    if (sample_cnt !== 5 || err_cnt !== 5 || sat !== 1'b0) begin
      failures++;
      $display("FAIL wide_no_sat got=%0d/%0d sat=%0b exp=5/5 sat=0", sample_cnt, err_cnt, sat);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_gaps();
    test_reset_mid();
    test_start_control();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
